// File: rtl/vx_tensor_commit_buffer.sv
// Packet-framed elastic buffer from the tensor commit stream to the commit stage; `VX_TENSOR_COMMIT_SAF_EN selects store-and-forward.
// One cycle from accept to out_valid (from the eop beat in store-and-forward); in_ready falls only when all DEPTH entries are held.

`ifndef UUID_WIDTH
`define UUID_WIDTH 44
`endif
`ifndef NW_WIDTH
`define NW_WIDTH 2
`endif
`ifndef NUM_THREADS
`define NUM_THREADS 4
`endif
`ifndef XLEN
`define XLEN 32
`endif
`ifndef NR_BITS
`define NR_BITS 6
`endif
`ifndef NUM_IREGS
`define NUM_IREGS 32
`endif

module vx_tensor_commit_buffer #(
    parameter int DEPTH     = 8,
    parameter int MAX_BEATS = 3
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [`UUID_WIDTH-1:0]           in_uuid,
    input  logic [`NW_WIDTH-1:0]             in_wid,
    input  logic [`NUM_THREADS-1:0]          in_tmask,
    input  logic [`XLEN-1:0]                 in_PC,
    input  logic                             in_wb,
    input  logic [`NR_BITS-1:0]              in_rd,
    input  logic                             in_tensor,
    input  logic [`NUM_THREADS*`XLEN-1:0]    in_data,
    input  logic                             in_sop,
    input  logic                             in_eop,
    input  logic                             in_pid,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [`UUID_WIDTH-1:0]           out_uuid,
    output logic [`NW_WIDTH-1:0]             out_wid,
    output logic [`NUM_THREADS-1:0]          out_tmask,
    output logic [`XLEN-1:0]                 out_PC,
    output logic                             out_wb,
    output logic [`NR_BITS-1:0]              out_rd,
    output logic                             out_tensor,
    output logic [`NUM_THREADS*`XLEN-1:0]    out_data,
    output logic                             out_sop,
    output logic                             out_eop,
    output logic                             out_pid,
    output logic [15:0]                      pkt_count,
    output logic                             framing_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int BW = $clog2(MAX_BEATS + 1);
    localparam logic [BW-1:0] MAX_CNT = BW'(MAX_BEATS);

    typedef struct packed {
        logic [`UUID_WIDTH-1:0]        uuid;
        logic [`NW_WIDTH-1:0]          wid;
        logic [`NUM_THREADS-1:0]       tmask;
        logic [`XLEN-1:0]              pc;
        logic                          wb;
        logic [`NR_BITS-1:0]           rd;
        logic                          tensor;
        logic [`NUM_THREADS*`XLEN-1:0] data;
        logic                          sop;
        logic                          eop;
        logic                          pid;
    } beat_t;

    typedef enum logic {IDLE, IN_PKT} chk_state_t;

    beat_t             in_beat;
    beat_t             head;
    beat_t             head_nxt;
    beat_t             mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [AW:0]       wr_ptr_nxt;
    logic [AW:0]       rd_ptr_nxt;
    logic [AW:0]       occ_nxt;
    logic              push;
    logic              pop;
    logic              full;
    logic              head_avail;
    logic              head_ok;
    chk_state_t        chk_state;
    logic [BW-1:0]     beat_cnt;
    logic [`NW_WIDTH-1:0] pkt_wid;

    always_comb begin
        in_beat        = '0;
        in_beat.uuid   = in_uuid;
        in_beat.wid    = in_wid;
        in_beat.tmask  = in_tmask;
        in_beat.pc     = in_PC;
        in_beat.wb     = in_wb;
        in_beat.rd     = in_rd;
        in_beat.tensor = in_tensor;
        in_beat.data   = in_data;
        in_beat.sop    = in_sop;
        in_beat.eop    = in_eop;
        in_beat.pid    = in_pid;
    end

    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign in_ready   = !full;
    assign push       = in_valid && !full;
    assign pop        = out_valid && out_ready;
    assign wr_ptr_nxt = wr_ptr + {{AW{1'b0}}, push};
    assign rd_ptr_nxt = rd_ptr + {{AW{1'b0}}, pop};
    assign occ_nxt    = wr_ptr_nxt - rd_ptr_nxt;
    assign head_avail = (occ_nxt != '0);

    // The output register mirrors the next head; when that slot is being written this cycle, bypass the array.
    assign head_nxt = (push && (rd_ptr_nxt == wr_ptr)) ? in_beat : mem[rd_ptr_nxt[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= in_beat;
        end
    end

`ifdef VX_TENSOR_COMMIT_SAF_EN
    localparam int CW = $clog2(DEPTH + 1);
    logic [CW-1:0] complete_pkts;
    logic [CW-1:0] complete_nxt;

    assign complete_nxt = complete_pkts + CW'(push && in_eop) - CW'(pop && head.eop);
    assign head_ok      = head_avail && (complete_nxt != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            complete_pkts <= '0;
        end else begin
            complete_pkts <= complete_nxt;
        end
    end

    // A packet that cannot fit would never complete and would block the buffer forever.
    if (DEPTH < MAX_BEATS) begin : g_depth_check
        $error("vx_tensor_commit_buffer: DEPTH must be >= MAX_BEATS in store-and-forward mode");
    end
`else
    assign head_ok = head_avail;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            out_valid <= 1'b0;
            head      <= '0;
            pkt_count <= '0;
        end else begin
            wr_ptr    <= wr_ptr_nxt;
            rd_ptr    <= rd_ptr_nxt;
            out_valid <= head_ok;
            if (head_avail) begin
                head <= head_nxt;
            end
            if (pop && head.eop) begin
                pkt_count <= pkt_count + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chk_state   <= IDLE;
            beat_cnt    <= '0;
            pkt_wid     <= '0;
            framing_err <= 1'b0;
        end else if (push) begin
            if (chk_state == IDLE || in_sop) begin
                // A stray sop inside a packet is flagged but still opens the next packet.
                if ((chk_state == IDLE && !in_sop) || (chk_state == IN_PKT && in_sop)) begin
                    framing_err <= 1'b1;
                end
                beat_cnt <= BW'(1);
                pkt_wid  <= in_wid;
            end else begin
                if (in_wid != pkt_wid) begin
                    framing_err <= 1'b1;
                end
                if (beat_cnt >= MAX_CNT) begin
                    framing_err <= 1'b1;
                end else begin
                    beat_cnt <= beat_cnt + BW'(1);
                end
            end
            chk_state <= in_eop ? IDLE : IN_PKT;
        end
    end

    assign out_uuid   = head.uuid;
    assign out_wid    = head.wid;
    assign out_tmask  = head.tmask;
    assign out_PC     = head.pc;
    assign out_wb     = head.wb;
    assign out_rd     = head.rd;
    assign out_tensor = head.tensor;
    assign out_data   = head.data;
    assign out_sop    = head.sop;
    assign out_eop    = head.eop;
    assign out_pid    = head.pid;

endmodule

// File: tb/tb_vx_tensor_commit_buffer.sv
// Bench for vx_tensor_commit_buffer: beat scoreboard, hand sequences and a framing table.
// Works for both the cut-through build and the VX_TENSOR_COMMIT_SAF_EN build.

`ifndef UUID_WIDTH
`define UUID_WIDTH 44
`endif
`ifndef NW_WIDTH
`define NW_WIDTH 2
`endif
`ifndef NUM_THREADS
`define NUM_THREADS 4
`endif
`ifndef XLEN
`define XLEN 32
`endif
`ifndef NR_BITS
`define NR_BITS 6
`endif
`ifndef NUM_IREGS
`define NUM_IREGS 32
`endif

module tb_vx_tensor_commit_buffer;

    localparam int UW  = `UUID_WIDTH;
    localparam int NWW = `NW_WIDTH;
    localparam int NT  = `NUM_THREADS;
    localparam int XL  = `XLEN;
    localparam int RB  = `NR_BITS;
`ifdef VX_TENSOR_COMMIT_SAF_EN
    localparam int FIRST_VLD = 2;
`else
    localparam int FIRST_VLD = 0;
`endif

    typedef struct packed {
        logic [UW-1:0]    uuid;
        logic [NWW-1:0]   wid;
        logic [NT-1:0]    tmask;
        logic [XL-1:0]    pc;
        logic             wb;
        logic [RB-1:0]    rd;
        logic             tensor;
        logic [NT*XL-1:0] data;
        logic             sop;
        logic             eop;
        logic             pid;
    } beat_t;

    typedef struct {
        int         n;
        logic [3:0] sop;
        logic [3:0] eop;
        logic [3:0] alt;
        int         err_at;
    } frm_vec_t;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [UW-1:0]    in_uuid;
    logic [NWW-1:0]   in_wid;
    logic [NT-1:0]    in_tmask;
    logic [XL-1:0]    in_PC;
    logic             in_wb;
    logic [RB-1:0]    in_rd;
    logic             in_tensor;
    logic [NT*XL-1:0] in_data;
    logic             in_sop;
    logic             in_eop;
    logic             in_pid;
    logic             out_valid;
    logic             out_ready;
    logic [UW-1:0]    out_uuid;
    logic [NWW-1:0]   out_wid;
    logic [NT-1:0]    out_tmask;
    logic [XL-1:0]    out_PC;
    logic             out_wb;
    logic [RB-1:0]    out_rd;
    logic             out_tensor;
    logic [NT*XL-1:0] out_data;
    logic             out_sop;
    logic             out_eop;
    logic             out_pid;
    logic [15:0]      pkt_count;
    logic             framing_err;

    int          n_pass;
    int          n_total;
    int          seq;
    logic [15:0] exp_pkt;
    logic [5:0]  vpat;
    beat_t       cur;
    beat_t       sb_q[$];
    frm_vec_t    vecs[7];

    vx_tensor_commit_buffer #(.DEPTH(8), .MAX_BEATS(3)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_uuid(in_uuid), .in_wid(in_wid), .in_tmask(in_tmask), .in_PC(in_PC),
        .in_wb(in_wb), .in_rd(in_rd), .in_tensor(in_tensor), .in_data(in_data),
        .in_sop(in_sop), .in_eop(in_eop), .in_pid(in_pid),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_uuid(out_uuid), .out_wid(out_wid), .out_tmask(out_tmask), .out_PC(out_PC),
        .out_wb(out_wb), .out_rd(out_rd), .out_tensor(out_tensor), .out_data(out_data),
        .out_sop(out_sop), .out_eop(out_eop), .out_pid(out_pid),
        .pkt_count(pkt_count), .framing_err(framing_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got %h required %h", name, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic beat_t dut_out();
        beat_t b;
        b.uuid   = out_uuid;
        b.wid    = out_wid;
        b.tmask  = out_tmask;
        b.pc     = out_PC;
        b.wb     = out_wb;
        b.rd     = out_rd;
        b.tensor = out_tensor;
        b.data   = out_data;
        b.sop    = out_sop;
        b.eop    = out_eop;
        b.pid    = out_pid;
        return b;
    endfunction

    task automatic drive_beat(input logic sop, input logic eop, input logic [NWW-1:0] wid,
                              input logic [RB-1:0] rd, input logic wb);
        beat_t b;
        seq++;
        b.uuid   = UW'(seq);
        b.wid    = wid;
        b.tmask  = NT'(seq) | NT'(1);
        b.pc     = XL'(32'h1000 + seq * 4);
        b.wb     = wb;
        b.rd     = rd;
        b.tensor = 1'b1;
        for (int t = 0; t < NT; t++) begin
            b.data[t*XL +: XL] = XL'(seq * 16 + t);
        end
        b.sop = sop;
        b.eop = eop;
        b.pid = seq[0];
        cur       = b;
        in_valid  = 1'b1;
        in_uuid   = b.uuid;
        in_wid    = b.wid;
        in_tmask  = b.tmask;
        in_PC     = b.pc;
        in_wb     = b.wb;
        in_rd     = b.rd;
        in_tensor = b.tensor;
        in_data   = b.data;
        in_sop    = b.sop;
        in_eop    = b.eop;
        in_pid    = b.pid;
    endtask

    // One clock: log the fires implied by current pins, then advance and check the packet counter.
    task automatic step();
        beat_t exp;
        if (in_valid && in_ready) begin
            sb_q.push_back(cur);
        end
        if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_pop", 1, 0);
            end else begin
                exp = sb_q.pop_front();
                chk("sb_beat", dut_out(), exp);
                if (exp.eop) exp_pkt++;
            end
        end
        @(posedge clk);
        #1;
        chk("pkt_count", pkt_count, exp_pkt);
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 64 && sb_q.size() > 0; i++) begin
            step();
        end
        chk("drain_empty", sb_q.size(), 0);
        chk("drain_idle_vld", out_valid, 0);
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        reset     = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_fields", dut_out(), 0);
        chk("rst_pkt_count", pkt_count, 0);
        chk("rst_framing_err", framing_err, 0);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb_q.delete();
        exp_pkt = '0;
    endtask

    initial begin
        n_pass = 0; n_total = 0; seq = 0; exp_pkt = '0;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_uuid = '0; in_wid = '0; in_tmask = '0; in_PC = '0; in_wb = 1'b0; in_rd = '0;
        in_tensor = 1'b0; in_data = '0; in_sop = 1'b0; in_eop = 1'b0; in_pid = 1'b0;
`ifdef VX_TENSOR_COMMIT_SAF_EN
        vpat = 6'b011100;
`else
        vpat = 6'b000111;
`endif
        vecs[0] = '{n:1, sop:4'b0000, eop:4'b0001, alt:4'b0000, err_at:0};
        vecs[1] = '{n:3, sop:4'b0001, eop:4'b0100, alt:4'b0110, err_at:1};
        vecs[2] = '{n:4, sop:4'b0001, eop:4'b1000, alt:4'b0000, err_at:3};
        vecs[3] = '{n:3, sop:4'b0001, eop:4'b0100, alt:4'b0000, err_at:99};
        vecs[4] = '{n:1, sop:4'b0001, eop:4'b0001, alt:4'b0000, err_at:99};
        vecs[5] = '{n:2, sop:4'b0011, eop:4'b0010, alt:4'b0000, err_at:1};
        vecs[6] = '{n:4, sop:4'b0011, eop:4'b1001, alt:4'b1110, err_at:99};

        @(posedge clk);
        #1;
        do_reset();

        // Single 3-beat packet, writeback on the last beat
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i < 3) drive_beat(i == 0, i == 2, '0, RB'(`NUM_IREGS + i + 1), i == 2);
            else in_valid = 1'b0;
            step();
            chk("single_out_valid", out_valid, vpat[i]);
        end
        chk("single_pkt_count", pkt_count, 16'd1);
        chk("single_framing_err", framing_err, 0);

        // Backpressure: fill all 8 entries with out_ready low
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive_beat(i == 0 || i == 3 || i == 6, i == 2 || i == 5 || i == 7, '0, RB'(i),
                       i == 2 || i == 5 || i == 7);
            step();
            chk("bp_in_ready", in_ready, i < 7);
            if (i >= FIRST_VLD) begin
                chk("bp_out_valid", out_valid, 1);
                chk("bp_head_stable", dut_out(), sb_q[0]);
            end
        end
        drain();
        chk("bp_pkt_count", pkt_count, 16'd4);

        // Push and pop together at occupancy 7
        out_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            drive_beat(1'b1, 1'b1, '0, RB'(i), 1'b1);
            step();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive_beat(1'b1, 1'b1, NWW'(i), RB'(i + 8), 1'b1);
            chk("pp_in_ready", in_ready, 1);
            chk("pp_out_valid", out_valid, 1);
            step();
        end
        out_ready = 1'b0;
        drive_beat(1'b1, 1'b1, '0, RB'(30), 1'b1);
        step();
        chk("pp_full_after_extra", in_ready, 0);
        drain();
        chk("pp_framing_err", framing_err, 0);

        // Reset in the middle of a packet, then a clean packet
        out_ready = 1'b0;
        drive_beat(1'b1, 1'b0, '0, RB'(`NUM_IREGS + 1), 1'b0);
        step();
        drive_beat(1'b0, 1'b0, '0, RB'(`NUM_IREGS + 2), 1'b0);
        step();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_beat(i == 0, i == 2, '0, RB'(`NUM_IREGS + i + 1), i == 2);
            step();
        end
        drain();
        chk("post_rst_pkt_count", pkt_count, 16'd1);
        chk("post_rst_framing_err", framing_err, 0);

`ifdef VX_TENSOR_COMMIT_SAF_EN
        // Incomplete packet must be held until its eop arrives
        do_reset();
        out_ready = 1'b1;
        drive_beat(1'b1, 1'b0, '0, RB'(`NUM_IREGS + 1), 1'b0);
        step();
        chk("saf_hold_b1", out_valid, 0);
        drive_beat(1'b0, 1'b0, '0, RB'(`NUM_IREGS + 2), 1'b0);
        step();
        chk("saf_hold_b2", out_valid, 0);
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("saf_hold_idle", out_valid, 0);
        end
        drive_beat(1'b0, 1'b1, '0, RB'(`NUM_IREGS + 3), 1'b1);
        step();
        chk("saf_release", out_valid, 1);
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("saf_burst", out_valid, i < 2);
        end
        chk("saf_pkt_count", pkt_count, 16'd1);
        chk("saf_sb_empty", sb_q.size(), 0);
`endif

        // Framing table: each row starts from reset
        for (int r = 0; r < 7; r++) begin
            do_reset();
            out_ready = 1'b1;
            for (int i = 0; i < vecs[r].n; i++) begin
                drive_beat(vecs[r].sop[i], vecs[r].eop[i], NWW'(vecs[r].alt[i]),
                           RB'(`NUM_IREGS + i + 1), vecs[r].eop[i]);
                step();
                chk($sformatf("frm%0d_err_beat%0d", r, i), framing_err, i >= vecs[r].err_at);
            end
            drain();
            chk($sformatf("frm%0d_pkts", r), pkt_count, 16'($countones(vecs[r].eop)));
            chk($sformatf("frm%0d_err_sticky", r), framing_err, vecs[r].err_at < vecs[r].n);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
